// File: rtl/mouse_pkg.sv
// -----------------------------------------------------------------------------
// mouse_pkg
// Shared PS/2 mouse definitions:
//   - the packet FSM state enum
//   - the byte-0 header fields the tracker keeps
//   - a signed clamp helper
// There are no ports in this file.
// -----------------------------------------------------------------------------
package mouse_pkg;

    typedef enum logic [1:0] {
        B0    = 2'd0,
        B1    = 2'd1,
        B2    = 2'd2,
        APPLY = 2'd3
    } mouse_state_e;

    // Bit 3 of a PS/2 mouse byte 0 is always 1. This is the only framing check.
    localparam int HDR_SYNC_BIT = 3;

    // Byte 0 fields that are used later in the packet. Bit 2 (middle button)
    // and bit 3 (sync) are not needed once the byte has been accepted.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic right;
        logic left;
    } mouse_hdr_t;

    function automatic mouse_hdr_t hdr_from_byte(input logic [7:0] b);
        mouse_hdr_t h;
        h.y_ovf  = b[7];
        h.x_ovf  = b[6];
        h.y_sign = b[5];
        h.x_sign = b[4];
        h.right  = b[1];
        h.left   = b[0];
        return h;
    endfunction

    // The function compares signed values. Callers pass a non-negative lo, so
    // the result always fits the 12-bit unsigned screen coordinate.
    function automatic logic [11:0] clamp_s13(input logic signed [12:0] val,
                                              input logic signed [12:0] lo,
                                              input logic signed [12:0] hi);
        logic [11:0] r;
        if (val < lo) begin
            r = lo[11:0];
        end else if (val > hi) begin
            r = hi[11:0];
        end else begin
            r = val[11:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared VGA timing constants. Blocks that work in screen coordinates take
// their limits from here. There are no ports in this file.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int VGA_H_ACTIVE = 800;
    localparam int VGA_V_ACTIVE = 600;

    // Largest visible pixel coordinate on each axis.
    localparam int VGA_H_MAX = VGA_H_ACTIVE - 1;
    localparam int VGA_V_MAX = VGA_V_ACTIVE - 1;

endpackage

// File: rtl/mouse_pos_tracker.sv
// -----------------------------------------------------------------------------
// mouse_pos_tracker
// Assembles 3-byte PS/2 mouse packets and integrates the deltas into a clamped
// cursor position. Position and button state are shown to the draw stage only
// on a vblnk rising edge, so the values stay constant for a whole frame.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous, active-high reset
//   rx_data   in   [7:0]  PS/2 byte from the upstream receiver
//   rx_valid  in   one-cycle strobe that qualifies rx_data
//   vblnk     in   vertical blank from the VGA timing chain
//   xpos      out  [11:0] frame-stable cursor X
//   ypos      out  [11:0] frame-stable cursor Y
//   left      out  frame-stable left button
//   right     out  frame-stable right button
//   pkt_err   out  one-cycle pulse on a rejected byte 0 or a packet timeout
//
// state | meaning
// ------+-------------------------------------------------------------
// B0    | idle, waiting for a byte 0 with the sync bit set
// B1    | byte 0 held, waiting for the X delta; idle timer running
// B2    | X delta held, waiting for the Y delta; idle timer running
// APPLY | one cycle: integrate the deltas; can also accept a new byte 0
// -----------------------------------------------------------------------------
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int H_MAX       = vga_pkg::VGA_H_MAX,
    parameter int V_MAX       = vga_pkg::VGA_V_MAX,
    parameter int X_INIT      = 400,
    parameter int Y_INIT      = 300,
    parameter int TIMEOUT_CYC = 65000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        vblnk,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        left,
    output logic        right,
    output logic        pkt_err
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    // The packet times out on the idle clock that would bring the count to
    // TIMEOUT_CYC.
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

    localparam logic signed [12:0] H_MAX_S = 13'(H_MAX);
    localparam logic signed [12:0] V_MAX_S = 13'(V_MAX);
    localparam logic signed [12:0] ZERO_S  = 13'sd0;
    localparam logic [11:0]        X_RST   = 12'(X_INIT);
    localparam logic [11:0]        Y_RST   = 12'(Y_INIT);

    mouse_state_e      state_q;
    mouse_hdr_t        hdr_q;
    logic [7:0]        b1_q;
    logic [7:0]        b2_q;
    logic [IDLE_W-1:0] idle_q;
    logic              vblnk_q;

    // Internal position and buttons. These are updated in APPLY.
    logic [11:0]       x_int_q;
    logic [11:0]       y_int_q;
    logic              left_int_q;
    logic              right_int_q;

    // Frame-stable copies that drive the outputs.
    logic [11:0]       xpos_q;
    logic [11:0]       ypos_q;
    logic              left_q;
    logic              right_q;
    logic              pkt_err_q;

    logic signed [12:0] dx_s;
    logic signed [12:0] dy_s;
    logic signed [12:0] x_sum;
    logic signed [12:0] y_sum;
    logic [11:0]        x_d;
    logic [11:0]        y_d;
    logic               vblnk_rise;

    assign vblnk_rise = vblnk & ~vblnk_q;

    // Each delta is 9-bit two's complement: the sign bit from byte 0 sits in
    // front of the byte. A set overflow bit makes the delta untrustworthy, so
    // the delta is dropped instead of being saturated.
    always_comb begin
        dx_s = '0;
        dy_s = '0;
        if (!hdr_q.x_ovf) begin
            dx_s = {{4{hdr_q.x_sign}}, hdr_q.x_sign, b1_q};
        end
        if (!hdr_q.y_ovf) begin
            dy_s = {{4{hdr_q.y_sign}}, hdr_q.y_sign, b2_q};
        end
        x_sum = $signed({1'b0, x_int_q}) + dx_s;
        // PS/2 Y counts upward, but screen Y counts downward.
        y_sum = $signed({1'b0, y_int_q}) - dy_s;
        x_d   = clamp_s13(x_sum, ZERO_S, H_MAX_S);
        y_d   = clamp_s13(y_sum, ZERO_S, V_MAX_S);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= B0;
            hdr_q       <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            idle_q      <= '0;
            vblnk_q     <= 1'b0;
            x_int_q     <= X_RST;
            y_int_q     <= Y_RST;
            left_int_q  <= 1'b0;
            right_int_q <= 1'b0;
            xpos_q      <= X_RST;
            ypos_q      <= Y_RST;
            left_q      <= 1'b0;
            right_q     <= 1'b0;
            pkt_err_q   <= 1'b0;
        end else begin
            pkt_err_q <= 1'b0;
            vblnk_q   <= vblnk;

            // The outputs capture the internal values as they were before
            // this edge. If APPLY happens on the same cycle, the update is
            // shown at the next frame.
            if (vblnk_rise) begin
                xpos_q  <= x_int_q;
                ypos_q  <= y_int_q;
                left_q  <= left_int_q;
                right_q <= right_int_q;
            end

            case (state_q)
                B0, APPLY: begin
                    if (state_q == APPLY) begin
                        x_int_q     <= x_d;
                        y_int_q     <= y_d;
                        left_int_q  <= hdr_q.left;
                        right_int_q <= hdr_q.right;
                    end
                    idle_q <= '0;
                    if (rx_valid) begin
                        if (rx_data[HDR_SYNC_BIT]) begin
                            hdr_q   <= hdr_from_byte(rx_data);
                            state_q <= B1;
                        end else begin
                            pkt_err_q <= 1'b1;
                            state_q   <= B0;
                        end
                    end else begin
                        state_q <= B0;
                    end
                end

                B1: begin
                    if (rx_valid) begin
                        b1_q    <= rx_data;
                        idle_q  <= '0;
                        state_q <= B2;
                    end else if (idle_q == IDLE_LAST) begin
                        idle_q    <= '0;
                        pkt_err_q <= 1'b1;
                        state_q   <= B0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end

                B2: begin
                    if (rx_valid) begin
                        b2_q    <= rx_data;
                        idle_q  <= '0;
                        state_q <= APPLY;
                    end else if (idle_q == IDLE_LAST) begin
                        idle_q    <= '0;
                        pkt_err_q <= 1'b1;
                        state_q   <= B0;
                    end else begin
                        idle_q <= idle_q + 1'b1;
                    end
                end

                default: begin
                    idle_q  <= '0;
                    state_q <= B0;
                end
            endcase
        end
    end

    assign xpos    = xpos_q;
    assign ypos    = ypos_q;
    assign left    = left_q;
    assign right   = right_q;
    assign pkt_err = pkt_err_q;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// -----------------------------------------------------------------------------
// tb_mouse_pos_tracker
// Directed test of the mouse packet tracker. All expected values are worked
// out by hand from the packet bytes. The idle timeout is shortened so that
// its boundary can be tested quickly.
// -----------------------------------------------------------------------------
module tb_mouse_pos_tracker;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        vblnk;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        right;
    logic        pkt_err;

    int n_pass  = 0;
    int n_total = 0;

    // Expected positions after each saturating packet.
    int sat_x [3] = '{655, 799, 799};
    int sat_y [3] = '{45, 0, 0};
    int neg_x [4] = '{543, 287, 31, 0};
    int neg_y [4] = '{256, 512, 599, 599};

    always #5 clk = ~clk;

    mouse_pos_tracker #(
        .H_MAX       (799),
        .V_MAX       (599),
        .X_INIT      (400),
        .Y_INIT      (300),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .vblnk    (vblnk),
        .xpos     (xpos),
        .ypos     (ypos),
        .left     (left),
        .right    (right),
        .pkt_err  (pkt_err)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expd);
        n_total++;
        assert (obs === expd) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
    endtask

    task automatic chk_out(input string tag, input int ex, input int ey,
                           input logic el, input logic er);
        chk({tag, ".x"}, xpos, 12'(ex));
        chk({tag, ".y"}, ypos, 12'(ey));
        chk({tag, ".left"}, {11'b0, left}, {11'b0, el});
        chk({tag, ".right"}, {11'b0, right}, {11'b0, er});
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send(b0);
        send(b1);
        send(b2);
        tick(1);
    endtask

    task automatic frame();
        vblnk = 1'b1;
        tick(1);
        vblnk = 1'b0;
        tick(1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        vblnk    = 1'b0;
        tick(3);
        chk_out("reset", 400, 300, 1'b0, 1'b0);
        chk("reset.pkt_err", {11'b0, pkt_err}, 12'd0);
        rst = 1'b0;
        tick(1);

        // dx=+10, dy=+5: Y goes up on screen.
        send_pkt(8'h08, 8'h0A, 8'h05);
        chk("hold_before_vblnk.x", xpos, 12'd400);
        frame();
        chk_out("basic", 410, 295, 1'b0, 1'b0);

        // dx=-10 with the left button pressed, starting from reset.
        do_reset();
        send_pkt(8'h19, 8'hF6, 8'h00);
        frame();
        chk_out("neg_dx_left", 390, 300, 1'b1, 1'b0);

        // +255 on both axes, repeated: X stops at H_MAX and Y at 0.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_pkt(8'h08, 8'hFF, 8'hFF);
            frame();
            chk($sformatf("sat_hi[%0d].x", i), xpos, 12'(sat_x[i]));
            chk($sformatf("sat_hi[%0d].y", i), ypos, 12'(sat_y[i]));
        end

        // -256 on both axes, repeated: X stops at 0 and Y at V_MAX.
        for (int i = 0; i < 4; i++) begin
            send_pkt(8'h38, 8'h00, 8'h00);
            frame();
            chk($sformatf("sat_lo[%0d].x", i), xpos, 12'(neg_x[i]));
            chk($sformatf("sat_lo[%0d].y", i), ypos, 12'(neg_y[i]));
        end

        // An overflow bit cancels only the delta on its own axis.
        send_pkt(8'h48, 8'h10, 8'h10);
        frame();
        chk_out("x_ovf", 0, 583, 1'b0, 1'b0);
        send_pkt(8'h88, 8'h10, 8'h10);
        frame();
        chk_out("y_ovf", 16, 583, 1'b0, 1'b0);

        // A byte 0 without the sync bit is rejected. A valid packet afterwards
        // is still applied.
        send(8'h00);
        chk("bad_b0.pkt_err", {11'b0, pkt_err}, 12'd1);
        tick(1);
        chk("bad_b0.pkt_err_pulse", {11'b0, pkt_err}, 12'd0);
        frame();
        chk("bad_b0.no_change.x", xpos, 12'd16);
        send_pkt(8'h0A, 8'h05, 8'h03);
        frame();
        chk_out("after_bad", 21, 580, 1'b0, 1'b1);

        // A fourth byte lands in APPLY and is treated as a new byte 0.
        send(8'h08);
        send(8'h01);
        send(8'h01);
        send(8'h00);
        chk("extra_byte.pkt_err", {11'b0, pkt_err}, 12'd1);
        frame();
        chk_out("extra_byte", 22, 579, 1'b0, 1'b0);

        // Timeout: the TO-th idle clock in B2 abandons the packet.
        send(8'h08);
        send(8'h0A);
        tick(TO - 1);
        chk("timeout.early", {11'b0, pkt_err}, 12'd0);
        tick(1);
        chk("timeout.pkt_err", {11'b0, pkt_err}, 12'd1);
        send(8'h05);
        chk("timeout.back_in_b0", {11'b0, pkt_err}, 12'd1);
        frame();
        chk_out("timeout.no_change", 22, 579, 1'b0, 1'b0);

        // A byte that arrives after TO-1 idle clocks is still accepted.
        send(8'h08);
        send(8'h0A);
        tick(TO - 1);
        send(8'h05);
        chk("gap_ok.pkt_err", {11'b0, pkt_err}, 12'd0);
        tick(1);
        frame();
        chk_out("gap_ok", 32, 574, 1'b0, 1'b0);

        // APPLY in the same cycle as the vblnk rise: this frame shows the old
        // position, and the next frame shows the new one.
        send(8'h08);
        send(8'h0A);
        send(8'h05);
        vblnk = 1'b1;
        tick(1);
        chk("coincide.old.x", xpos, 12'd32);
        chk("coincide.old.y", ypos, 12'd574);
        vblnk = 1'b0;
        tick(1);
        chk("coincide.hold.x", xpos, 12'd32);
        frame();
        chk("coincide.new.x", xpos, 12'd42);
        chk("coincide.new.y", ypos, 12'd569);

        // Reset in the middle of a packet drops the partial packet. The
        // leftover byte 2 is then rejected as a byte 0.
        send(8'h08);
        send(8'h0A);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        send(8'h05);
        chk("mid_reset.pkt_err", {11'b0, pkt_err}, 12'd1);
        frame();
        chk_out("mid_reset", 400, 300, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mouse_pos_tracker.md
MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 SHALL have parameter H_MAX, default 799, meaning the largest allowed xpos.
REQ-002 SHALL have parameter V_MAX, default 599, meaning the largest allowed ypos.
REQ-003 SHALL have parameter X_INIT, default 400, meaning the xpos value after reset.
REQ-004 SHALL have parameter Y_INIT, default 300, meaning the ypos value after reset.
REQ-005 SHALL have parameter TIMEOUT_CYC, default 65000, meaning the maximum number of idle clocks allowed between bytes of one packet.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge clocked.
REQ-007 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port rx_data, input, 8 bits: a PS/2 byte from the upstream receiver.
REQ-009 SHALL have port rx_valid, input, 1 bit: a one-cycle strobe qualifying rx_data.
REQ-010 SHALL have port vblnk, input, 1 bit: the vertical blank signal from the VGA timing chain.
REQ-011 SHALL have port xpos, output, 12 bits: the frame-stable cursor X fed to the mouse-draw stage.
REQ-012 SHALL have port ypos, output, 12 bits: the frame-stable cursor Y fed to the mouse-draw stage.
REQ-013 SHALL have port left, output, 1 bit: the frame-stable left-button state.
REQ-014 SHALL have port right, output, 1 bit: the frame-stable right-button state.
REQ-015 SHALL have port pkt_err, output, 1 bit: a one-cycle pulse on a rejected byte 0 or on a packet timeout.

Function
REQ-016 SHALL implement the FSM states B0, B1, B2 and APPLY.
- B0 waits for byte 0.
- B1 waits for the X delta.
- B2 waits for the Y delta.
- APPLY lasts exactly one cycle.
REQ-017 SHALL, in B0 (or APPLY) with rx_valid=1 and rx_data[3]=1, store byte 0 and go to B1.
REQ-018 SHALL, in B0 (or APPLY) with rx_valid=1 and rx_data[3]=0, discard the byte, stay in or return to B0, and pulse pkt_err.
REQ-019 SHALL go B1->B2 on rx_valid and B2->APPLY on rx_valid, storing byte 1 and byte 2 respectively.
REQ-020 SHALL keep an idle counter in B1 and B2, cleared on every accepted byte; when it reaches TIMEOUT_CYC it goes to B0, pulses pkt_err and applies no update.
REQ-021 SHALL, in APPLY, compute dx={b0[4],b1} and dy={b0[5],b2} as 9-bit two's complement, sign-extended to 13-bit signed.
REQ-022 SHALL, in APPLY, set internal x = clamp(x+dx, 0, H_MAX) and internal y = clamp(y-dy, 0, V_MAX), since PS/2 Y is up-positive.
REQ-023 SHALL treat a delta as 0 when its overflow bit is set (b0[6] for X, b0[7] for Y).
REQ-024 SHALL, in APPLY, update the internal button state from b0[0] (left) and b0[1] (right).
REQ-025 SHALL register vblnk once and detect its rising edge as vblnk=1 with the registered copy=0.
REQ-026 SHALL, on the cycle after the vblnk rising edge, show the internal x/y/left/right values on the outputs; outputs hold at all other times.
REQ-027 SHALL, when APPLY and a vblnk rising edge occur in the same cycle, latch the pre-APPLY internal values; the new values appear at the next frame.
REQ-028 SHALL give a latency from the byte-2 strobe to the internal update of 1 cycle, and to the outputs the next vblnk rise plus 1 cycle.
REQ-029 SHALL ignore rx_valid pulses whose byte count exceeds the packet length, i.e. treat them as a new byte 0.

Reset
REQ-030 SHALL, with rst=1, set FSM=B0, the idle counter to 0, stored bytes to 0, and the registered vblnk to 0.
REQ-031 SHALL, with rst=1, set both internal and output xpos=X_INIT, ypos=Y_INIT, left=0, right=0 and pkt_err=0.
REQ-032 SHALL discard a partial packet when reset arrives mid-packet, with no position change.

Structure
REQ-033 SHALL take H_MAX/V_MAX defaults from the shared VGA package constants; the FSM state enum and a signed clamp function SHALL live in a shared mouse package.
REQ-034 SHALL be a single module with no sub-module; the upstream PS/2 byte receiver is a separate, existing block.

Verification
REQ-035 SHALL cover: after reset, send bytes 0x08,0x0A,0x05, then pulse vblnk -> xpos=410, ypos=295, left=0.
REQ-036 SHALL cover: bytes 0x19,0xF6,0x00 (dx=-10, left pressed) -> xpos=390, left=1 after the next vblnk.
REQ-037 SHALL cover: from X_INIT, 3 packets with dx=+255 -> xpos saturates at 799 and never wraps; likewise dy=+255 repeated -> ypos=0.
REQ-038 SHALL cover: byte 0x00 as byte 0 -> pkt_err pulse, no state change; then a valid packet is applied correctly.
REQ-039 SHALL cover: 0x08,0x0A then a gap of TIMEOUT_CYC clocks -> pkt_err pulse, FSM=B0, position unchanged.
REQ-040 SHALL cover: byte 2 strobe timed so APPLY coincides with the vblnk rise -> old position shown this frame, new position at the next vblnk.
